// File: rtl/ifu_pkg.sv
// Shared constants for the fetch/decode boundary: bubble instruction and
// the occupancy states of the IF->ID skid stage.
package ifu_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

endpackage

// File: rtl/skid_slot.sv
// One {instruction, address} holding register with load enable and a
// synchronous clear back to the bubble values (clear wins over load).
module skid_slot
  import ifu_pkg::*;
#(
  parameter int                INS_W    = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [INS_W-1:0]  NOP_VAL  = INS_W'(NOP),
  parameter logic [ADDR_W-1:0] ADDR_RST = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic [INS_W-1:0]  d_ins,
  input  logic [ADDR_W-1:0] d_addr,
  output logic [INS_W-1:0]  q_ins,
  output logic [ADDR_W-1:0] q_addr
);

  logic [INS_W-1:0]  ins_q, ins_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    ins_d  = ins_q;
    addr_d = addr_q;
    if (clr) begin
      ins_d  = NOP_VAL;
      addr_d = ADDR_RST;
    end else if (load) begin
      ins_d  = d_ins;
      addr_d = d_addr;
    end
  end

  always_ff @(posedge clk) begin
    ins_q  <= ins_d;
    addr_q <= addr_d;
  end

  assign q_ins  = ins_q;
  assign q_addr = addr_q;

endmodule

// File: rtl/if_id_skid.sv
// IF->ID pipeline register with a registered in_ready and a second (skid)
// slot that absorbs the word arriving in the cycle decode first stalls.
module if_id_skid
  import ifu_pkg::*;
#(
  parameter int                INS_W    = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [INS_W-1:0]  NOP_VAL  = INS_W'(NOP),
  parameter logic [ADDR_W-1:0] ADDR_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INS_W-1:0]  in_ins,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INS_W-1:0]  out_ins,
  output logic [ADDR_W-1:0] out_addr
);

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              main_clr, main_load, main_from_skid;
  logic              skid_clr, skid_load;
  logic [INS_W-1:0]  main_d_ins, skid_ins;
  logic [ADDR_W-1:0] main_d_addr, skid_addr;

  always_comb begin
    state_d        = state_q;
    main_clr       = 1'b0;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_clr       = 1'b0;
    skid_load      = 1'b0;
    if (rst || flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            main_load = 1'b1;
            state_d   = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            // main must fall back to the bubble when it drains empty
            if (in_valid) main_load = 1'b1;
            else begin
              main_clr = 1'b1;
              state_d  = ST_EMPTY;
            end
          end else if (in_valid) begin
            skid_load = 1'b1;
            state_d   = ST_SKID;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ST_FULL;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
    in_ready_d = (state_d != ST_SKID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign main_d_ins  = main_from_skid ? skid_ins  : in_ins;
  assign main_d_addr = main_from_skid ? skid_addr : in_addr;

  skid_slot #(
    .INS_W(INS_W), .ADDR_W(ADDR_W), .NOP_VAL(NOP_VAL), .ADDR_RST(ADDR_RST)
  ) u_main (
    .clk   (clk),
    .clr   (main_clr),
    .load  (main_load),
    .d_ins (main_d_ins),
    .d_addr(main_d_addr),
    .q_ins (out_ins),
    .q_addr(out_addr)
  );

  skid_slot #(
    .INS_W(INS_W), .ADDR_W(ADDR_W), .NOP_VAL(NOP_VAL), .ADDR_RST(ADDR_RST)
  ) u_skid (
    .clk   (clk),
    .clr   (skid_clr),
    .load  (skid_load),
    .d_ins (in_ins),
    .d_addr(in_addr),
    .q_ins (skid_ins),
    .q_addr(skid_addr)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed scenarios plus random valid/ready/flush,
// scored against a FIFO of words the stage currently holds.
module tb_if_id_skid;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_ins, in_addr, out_ins, out_addr;

  always #5 clk = ~clk;

  if_id_skid dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ins   (in_ins),
    .in_addr  (in_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ins  (out_ins),
    .out_addr (out_addr)
  );

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] addr;
  } item_t;

  item_t sb[$];
  int    checks   = 0;
  int    failures = 0;
  bit    mon_en   = 1'b0;
  bit    seen_20  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Just before each rising edge: the held-word FIFO predicts every output.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (mon_en) begin
        chk("out_valid", 64'(out_valid), 64'(sb.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
        if (sb.size() > 0) begin
          chk("out_ins", 64'(out_ins), 64'(sb[0].ins));
          chk("out_addr", 64'(out_addr), 64'(sb[0].addr));
        end else begin
          chk("bubble_ins", 64'(out_ins), 64'(NOP_W));
          chk("bubble_addr", 64'(out_addr), 64'd0);
        end
        if (out_valid && out_addr == 32'h20) seen_20 = 1'b1;
        if (rst || flush) sb.delete();
        else if (out_ready && sb.size() > 0) void'(sb.pop_front());
      end
    end
  end

  task automatic cycle(input logic r, input logic f, input logic v,
                       input logic [31:0] ins, input logic [31:0] addr,
                       input logic ordy, output bit acc);
    @(negedge clk);
    rst = r; flush = f; in_valid = v; in_ins = ins; in_addr = addr; out_ready = ordy;
    acc = v && in_ready && !r && !f;
    @(posedge clk);
    #1;
    if (acc) sb.push_back({ins, addr});
  endtask

  task automatic idle(input logic ordy, input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ordy, a);
  endtask

  initial begin
    bit          acc, have;
    logic [31:0] p_ins, p_addr;
    logic [31:0] stream_ins [3];
    int          n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ins = '0; in_addr = '0; out_ready = 1'b0;

    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
    mon_en = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
    idle(1'b0, 1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_ins", 64'(out_ins), 64'(NOP_W));
    chk("reset_out_addr", 64'(out_addr), 64'd0);

    stream_ins[0] = 32'h00A0_0093;
    stream_ins[1] = 32'h0010_8113;
    stream_ins[2] = 32'h0021_81B3;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, stream_ins[i], 32'(i * 4), 1'b1, acc);
      chk("stream_ins", 64'(out_ins), 64'(stream_ins[i]));
      chk("stream_valid", 64'(out_valid), 64'd1);
    end
    idle(1'b1, 2);

    cycle(1'b0, 1'b0, 1'b1, 32'h1111_1111, 32'h10, 1'b0, acc);
    cycle(1'b0, 1'b0, 1'b1, 32'h2222_2222, 32'h14, 1'b0, acc);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 32'h3333_3333, 32'h18, 1'b0, acc);
      chk("stall_hold_addr", 64'(out_addr), 64'h10);
    end
    n = 0;
    do begin
      cycle(1'b0, 1'b0, 1'b1, 32'h3333_3333, 32'h18, 1'b1, acc);
      n++;
    end while (!acc && n < 10);
    chk("stall_accept_18", 64'(acc), 64'd1);
    idle(1'b1, 3);

    cycle(1'b0, 1'b0, 1'b1, 32'h4444_4444, 32'h100, 1'b0, acc);
    cycle(1'b0, 1'b0, 1'b1, 32'h5555_5555, 32'h104, 1'b0, acc);
    cycle(1'b0, 1'b1, 1'b1, 32'h6666_6666, 32'h20, 1'b1, acc);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_out_ins", 64'(out_ins), 64'(NOP_W));
    chk("flush_out_addr", 64'(out_addr), 64'd0);
    idle(1'b1, 2);

    cycle(1'b0, 1'b0, 1'b1, 32'h7777_7777, 32'h30, 1'b0, acc);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_ins", 64'(out_ins), 64'(NOP_W));
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'h8888_8888, 32'h40, 1'b0, acc);
    chk("post_rst_addr", 64'(out_addr), 64'h40);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    idle(1'b1, 2);

    have = 1'b0; p_ins = '0; p_addr = '0; n = 0;
    for (int i = 0; i < 10000; i++) begin
      bit f;
      if (!have && $urandom_range(9) < 7) begin
        have   = 1'b1;
        p_ins  = $urandom;
        p_addr = 32'h1000 + 32'(n * 4);
        n++;
      end
      f = ($urandom_range(99) == 0);
      cycle(1'b0, f, have, p_ins, p_addr, $urandom_range(9) < 6, acc);
      if (acc || f) have = 1'b0;
    end
    idle(1'b1, 4);
    chk("drained", 64'(sb.size()), 64'd0);
    chk("flushed_20_never_out", 64'(seen_20), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
